// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver FSM state encodings.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_BREAK  = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP,
      BREAK  = ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability flop chain for an asynchronous serial line; resets to the idle level.
module uart_rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   import uart_pkg::*;

   logic [STAGES-1:0] chain;

   // NOTE: non-blocking assignments so each stage captures the previous stage's old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) chain <= {STAGES{UART_IDLE_LEVEL}};
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_byte_receiver.sv
// UART receiver: frames 8N1 bytes (8E1 when UART_RX_PARITY_EN is defined) and emits a
// fixed-width rx_accumulate strobe per good byte.
module uart_rx_byte_receiver #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PULSE_CYCLES = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_enable,
   output logic [7:0] rx_data,
   output logic       rx_accumulate,
   output logic       framing_error,
   output logic       parity_error,
   output logic       busy
);
   import uart_pkg::*;

   localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] MID_LAST   = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);

   rx_state_t                 state, state_nxt;
   logic [15:0]               bit_cnt, bit_cnt_nxt;
   logic [2:0]                bit_idx;
   logic [UART_DATA_BITS-1:0] shreg;
   logic [15:0]               pulse_cnt;
   logic                      rxs;
   logic                      sample, accept, ferr;
`ifdef UART_RX_PARITY_EN
   logic                      parity_bit, parity_bad, perr;
   assign parity_bad = ^{shreg, parity_bit};
`endif

   uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   // NOTE: every signal driven here gets a default first so no latch can be inferred.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt + 16'd1;
      sample      = 1'b0;
      accept      = 1'b0;
      ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr        = 1'b0;
`endif
      case (state)
         IDLE: begin
            bit_cnt_nxt = '0;
            if (rx_enable && rxs != UART_IDLE_LEVEL) state_nxt = START;
         end
         START: if (bit_cnt == MID_LAST) begin
            // Re-centre here so later samples land mid-bit one full bit apart.
            bit_cnt_nxt = '0;
            if (rxs == UART_IDLE_LEVEL) state_nxt = IDLE;
            else                        state_nxt = DATA;
         end
         DATA: if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            sample      = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'(UART_DATA_BITS - 1)) state_nxt = PARITY;
`else
            if (bit_idx == 3'(UART_DATA_BITS - 1)) state_nxt = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = STOP;
         end
`endif
         STOP: if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            if (rxs != UART_IDLE_LEVEL) begin
               ferr      = 1'b1;
               state_nxt = BREAK;
            end else begin
`ifdef UART_RX_PARITY_EN
               perr   = parity_bad;
               accept = !parity_bad;
`else
               accept = 1'b1;
`endif
               state_nxt = IDLE;
            end
         end
         BREAK: begin
            bit_cnt_nxt = '0;
            if (rxs == UART_IDLE_LEVEL) state_nxt = IDLE;
         end
         default: begin
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_idx       <= '0;
         shreg         <= '0;
         rx_data       <= '0;
         pulse_cnt     <= '0;
         framing_error <= 1'b0;
      end else begin
         framing_error <= ferr;
         if (state == IDLE)  bit_idx <= '0;
         else if (sample)    bit_idx <= bit_idx + 3'd1;
         if (sample)         shreg   <= {rxs, shreg[UART_DATA_BITS-1:1]};
         if (accept)         rx_data <= shreg;
         // The strobe runs off its own counter so a new frame can start under it.
         if (accept)                 pulse_cnt <= PULSE_LOAD;
         else if (pulse_cnt != '0)   pulse_cnt <= pulse_cnt - 16'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_bit   <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         parity_error <= perr;
         if (state == PARITY && bit_cnt == BIT_LAST) parity_bit <= rxs;
      end
   end
`else
   assign parity_error = 1'b0;
`endif

   assign rx_accumulate = (pulse_cnt != '0);
   assign busy          = (state != IDLE);

endmodule
